// File: rtl/buffer_stream_reader_if.sv
// Handshake and memory-port bundle between the read sequencer, the bank
// loader, the memory controller and the systolic-array feeder.
interface buffer_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH:0]   tile_len;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [1:0]            bank_valid;
  logic [1:0]            bank_release;
  logic                  mem_read_enable;
  logic                  mem_buffer_select;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;
  logic                  tile_done;

  // Environment side: loader, memory controller and stream consumer.
  modport master (
    output start, tile_len, base_addr, bank_valid, mem_rd_data, out_ready,
    input  bank_release, mem_read_enable, mem_buffer_select, mem_rd_addr,
           out_valid, out_data, out_last, busy, tile_done
  );

  // Reader side.
  modport slave (
    input  start, tile_len, base_addr, bank_valid, mem_rd_data, out_ready,
    output bank_release, mem_read_enable, mem_buffer_select, mem_rd_addr,
           out_valid, out_data, out_last, busy, tile_done
  );
endinterface

// File: rtl/buffer_stream_reader.sv
// Ping-pong bank read sequencer: issues credit-limited single-cycle reads and
// streams the words through a 2-entry output FIFO with valid/ready backpressure.
module buffer_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input logic                    clk,
  input logic                    rst_n,
  buffer_stream_reader_if.slave  bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BANK = 2'd1;
  localparam logic [1:0] S_STREAM    = 2'd2;
  localparam logic [1:0] S_DRAIN     = 2'd3;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  logic [1:0]            state, state_next;
  logic                  cur_bank;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   issue_count;
  logic                  inflight, inflight_last;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic [1:0]            fifo_count;
  logic                  wr_ptr, rd_ptr;

  logic                  busy_q, tile_done_q;
  logic [1:0]            bank_release_q;

  logic                  out_valid, pop, credit, issue, issue_is_last;
  logic                  start_tile, start_empty, tile_end;
  logic [2:0]            occupancy;

  assign out_valid   = (fifo_count != 2'd0);
  assign pop         = out_valid & bus.out_ready;
  assign start_tile  = (state == S_IDLE) & bus.start & (bus.tile_len != '0);
  assign start_empty = (state == S_IDLE) & bus.start & (bus.tile_len == '0);

  // Words already committed (buffered or one cycle from arriving) minus the one
  // leaving now; a new read is only allowed while this stays below the depth.
  assign occupancy     = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign credit        = (occupancy < 3'd2);
  assign issue         = (state == S_STREAM) & credit;
  assign issue_is_last = (issue_count + CNT_ONE == len_q);
  assign tile_end      = (state == S_DRAIN) & pop & fifo_last[rd_ptr];

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start_tile) state_next = S_WAIT_BANK;
      S_WAIT_BANK: if (bus.bank_valid[cur_bank]) state_next = S_STREAM;
      S_STREAM:    if (issue && issue_is_last) state_next = S_DRAIN;
      S_DRAIN:     if (tile_end) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cur_bank       <= 1'b0;
      len_q          <= '0;
      base_q         <= '0;
      issue_count    <= '0;
      inflight       <= 1'b0;
      inflight_last  <= 1'b0;
      // NOTE: the two FIFO slots are reset as well because out_data is read
      // straight from them and must be zero out of reset.
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last      <= '0;
      fifo_count     <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      busy_q         <= 1'b0;
      tile_done_q    <= 1'b0;
      bank_release_q <= '0;
    end else begin
      state          <= state_next;
      busy_q         <= (state_next != S_IDLE);
      tile_done_q    <= tile_end | start_empty;
      bank_release_q <= tile_end ? (cur_bank ? 2'b10 : 2'b01) : 2'b00;
      if (tile_end) cur_bank <= ~cur_bank;

      if (start_tile) begin
        len_q       <= bus.tile_len;
        base_q      <= bus.base_addr;
        issue_count <= '0;
      end else if (issue) begin
        issue_count <= issue_count + CNT_ONE;
      end

      inflight      <= issue;
      inflight_last <= issue & issue_is_last;

      // Clearing the tag on pop keeps a stale last marker off out_last; a
      // push into the same slot later in this block takes precedence.
      if (pop) begin
        fifo_last[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
      end
      if (inflight) begin
        fifo_data[wr_ptr] <= bus.mem_rd_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.mem_read_enable   = issue;
  assign bus.mem_rd_addr       = base_q + issue_count[ADDR_WIDTH-1:0];
  assign bus.mem_buffer_select = cur_bank;
  assign bus.out_valid         = out_valid;
  assign bus.out_data          = fifo_data[rd_ptr];
  assign bus.out_last          = fifo_last[rd_ptr];
  assign bus.busy              = busy_q;
  assign bus.tile_done         = tile_done_q;
  assign bus.bank_release      = bank_release_q;

endmodule
